alu_share_arbiter: RTL and testbench

//   Shares one 16-bit ALU (3-bit op: ADD,SUB,AND,OR,XOR,NOT A,SHL,SHR) between NUM_REQ requesters.

---
 rtl/alu_share_if.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 118 +++++++++++
 tb/tb_alu_share_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// Bundle of every signal between the arbiter, its requesters, the shared ALU
// and the response consumer.
//   slave  : the arbiter side (takes requests and ALU results, drives ALU
//            operands and responses)
//   master : the environment side (requesters, ALU, response consumer)
// Signals:
//   req_valid/req_ready   per-requester handshake, NUM_REQ bits
//   req_a/req_b/req_op    packed per-requester operands, requester i at [i*W +: W]
//   alu_a/alu_b/alu_op    registered operands to the ALU
//   alu_res/zero/neg      combinational ALU result and flags
//   rsp_*                 captured response and its handshake
//   busy                  arbiter not idle
interface alu_share_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 16,
    parameter int ID_W    = 1
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*3-1:0]      req_op;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [2:0]                alu_op;
    logic [DATA_W-1:0]         alu_res;
    logic                      alu_zero;
    logic                      alu_neg;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_zero;
    logic                      rsp_neg;
    logic                      busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_res, alu_zero, alu_neg, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data, rsp_zero,
               rsp_neg, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_res, alu_zero, alu_neg, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data, rsp_zero,
               rsp_neg, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// A granted request's operands are registered onto the ALU for one cycle, the
// result and flags are captured, then held as a response until accepted.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_share_if.slave carrying request, ALU and response signals
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; req_ready asserted to the granted one
// EXEC  | latched operands on the ALU; result captured at end of cycle
// RESP  | rsp_valid high, response held until rsp_ready
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 16,
    parameter int ID_W    = 1
) (
    input logic        clk,
    input logic        rst_n,
    alu_share_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [2:0]        alu_op_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_zero_q, rsp_neg_q;

    logic [DATA_W-1:0] a_arr  [NUM_REQ];
    logic [DATA_W-1:0] b_arr  [NUM_REQ];
    logic [2:0]        op_arr [NUM_REQ];

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic              accept;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i]  = bus.req_a[i*DATA_W +: DATA_W];
        assign b_arr[i]  = bus.req_b[i*DATA_W +: DATA_W];
        assign op_arr[i] = bus.req_op[i*3 +: 3];
    end

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept = (state_q == IDLE) && grant_found;

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = accept && (grant_idx == ID_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_neg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a_q      <= a_arr[grant_idx];
                alu_b_q      <= b_arr[grant_idx];
                alu_op_q     <= op_arr[grant_idx];
                rsp_id_q     <= grant_idx;
                last_grant_q <= grant_idx;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= bus.alu_res;
                rsp_zero_q <= bus.alu_zero;
                rsp_neg_q  <= bus.alu_neg;
            end
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_neg   = rsp_neg_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_share_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   acc_cyc;
    int   prev_acc;

    alu_share_if #(.NUM_REQ(2), .DATA_W(16), .ID_W(1)) bus ();

    alu_share_arbiter #(.NUM_REQ(2), .DATA_W(16), .ID_W(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        bus.alu_res = 16'h0000;
        case (bus.alu_op)
            3'd0: bus.alu_res = bus.alu_a + bus.alu_b;
            3'd1: bus.alu_res = bus.alu_a - bus.alu_b;
            3'd2: bus.alu_res = bus.alu_a & bus.alu_b;
            3'd3: bus.alu_res = bus.alu_a | bus.alu_b;
            3'd4: bus.alu_res = bus.alu_a ^ bus.alu_b;
            3'd5: bus.alu_res = ~bus.alu_a;
            3'd6: bus.alu_res = bus.alu_a << 1;
            3'd7: bus.alu_res = bus.alu_a >> 1;
            default: bus.alu_res = 16'h0000;
        endcase
        bus.alu_zero = (bus.alu_res == 16'h0000);
        bus.alu_neg  = bus.alu_res[15];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op);
        if (idx == 0) begin
            bus.req_a[15:0] = a;
            bus.req_b[15:0] = b;
            bus.req_op[2:0] = op;
        end else begin
            bus.req_a[31:16] = a;
            bus.req_b[31:16] = b;
            bus.req_op[5:3]  = op;
        end
    endtask

    // Single-requester operation with rsp_ready held high; called at posedge+1 in IDLE.
    task automatic do_op(input string tag, input int idx, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] op, input logic [15:0] exp_d,
                         input logic exp_z, input logic exp_n);
        set_req(idx, a, b, op);
        bus.req_valid = (idx == 0) ? 2'b01 : 2'b10;
        bus.rsp_ready = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(bus.req_ready), (idx == 0) ? 32'h1 : 32'h2);
        step();
        bus.req_valid = 2'b00;
        #1;
        check({tag, "_exec_busy"}, 32'(bus.busy), 32'h1);
        check({tag, "_exec_nvalid"}, 32'(bus.rsp_valid), 32'h0);
        check({tag, "_alu_a"}, 32'(bus.alu_a), 32'(a));
        check({tag, "_alu_op"}, 32'(bus.alu_op), 32'(op));
        step();
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'h1);
        check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_d));
        check({tag, "_zero"}, 32'(bus.rsp_zero), 32'(exp_z));
        check({tag, "_neg"}, 32'(bus.rsp_neg), 32'(exp_n));
        check({tag, "_id"}, 32'(bus.rsp_id), 32'(idx));
        step();
        check({tag, "_idle"}, 32'(bus.busy), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
        check({tag, "_alu_a"}, 32'(bus.alu_a), 32'h0);
        check({tag, "_alu_b"}, 32'(bus.alu_b), 32'h0);
        check({tag, "_alu_op"}, 32'(bus.alu_op), 32'h0);
        check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'h0);
        check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'h0);
        check({tag, "_rsp_flags"}, 32'({bus.rsp_zero, bus.rsp_neg}), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        prev_acc      = 0;
        acc_cyc       = 0;
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;

        // Reset state, then idle with no requests
        step();
        step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();
        step();
        check_reset_outputs("idle");

        // Basic ops from requester 0, including wrap and shift boundaries
        do_op("add", 0, 16'd5, 16'd3, 3'd0, 16'h0008, 1'b0, 1'b0);
        do_op("addwrap", 0, 16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, 1'b0);
        do_op("not", 0, 16'h00FF, 16'h1234, 3'd5, 16'hFF00, 1'b0, 1'b1);
        do_op("shl", 0, 16'h8001, 16'h0000, 3'd6, 16'h0002, 1'b0, 1'b0);
        do_op("shr", 0, 16'h8000, 16'h0000, 3'd7, 16'h4000, 1'b0, 1'b0);
        do_op("xor", 0, 16'hF0F0, 16'hFF00, 3'd4, 16'h0FF0, 1'b0, 1'b0);

        // Requester 1 subtraction, negative and zero results
        do_op("subneg", 1, 16'd3, 16'd5, 3'd1, 16'hFFFE, 1'b0, 1'b1);
        do_op("subzero", 1, 16'd5, 16'd5, 3'd1, 16'h0000, 1'b1, 1'b0);

        // Both requesting continuously: alternating grants, 3 cycles apart
        set_req(0, 16'd1, 16'd2, 3'd0);
        set_req(1, 16'd10, 16'd4, 3'd1);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready", 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            acc_cyc = cyc;
            if (k > 0) check("rr_spacing", 32'(acc_cyc - prev_acc), 32'd3);
            prev_acc = acc_cyc;
            step();
            step();
            check("rr_id", 32'(bus.rsp_id), 32'(k % 2));
            check("rr_data", 32'(bus.rsp_data), (k % 2 == 0) ? 32'h0003 : 32'h0006);
            step();
        end
        bus.req_valid = 2'b00;
        step();

        // Back-pressure in RESP; requester 1 waits meanwhile
        set_req(0, 16'h0007, 16'h0009, 3'd3);
        set_req(1, 16'h0100, 16'h0001, 3'd0);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b0;
        #1;
        check("bp_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 2'b10;
        step();
        for (int k = 0; k < 4; k++) begin
            check("bp_valid", 32'(bus.rsp_valid), 32'h1);
            check("bp_data", 32'(bus.rsp_data), 32'h000F);
            check("bp_id", 32'(bus.rsp_id), 32'h0);
            check("bp_noready", 32'(bus.req_ready), 32'h0);
            check("bp_busy", 32'(bus.busy), 32'h1);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        check("bp_idle", 32'(bus.busy), 32'h0);
        check("bp_rsp_drop", 32'(bus.rsp_valid), 32'h0);
        check("bp_next_grant", 32'(bus.req_ready), 32'h2);
        bus.req_valid = 2'b00;
        step();

        // Reset during EXEC discards the op and restores the round-robin pointer
        set_req(0, 16'h0011, 16'h0022, 3'd0);
        bus.req_valid = 2'b01;
        #1;
        check("rx_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 2'b00;
        check("rx_in_exec", 32'(bus.busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rx_busy", 32'(bus.busy), 32'h0);
        check("rx_alu_a", 32'(bus.alu_a), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rx_novalid", 32'(bus.rsp_valid), 32'h0);
        end
        set_req(0, 16'h0020, 16'h0003, 3'd2);
        set_req(1, 16'h0030, 16'h0003, 3'd4);
        bus.req_valid = 2'b11;
        rst_n = 1'b1;
        #1;
        check("rx_first_grant", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 2'b00;
        step();
        check("rx_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("rx_rsp_id", 32'(bus.rsp_id), 32'h0);
        check("rx_rsp_data", 32'(bus.rsp_data), 32'h0000);
        check("rx_rsp_zero", 32'(bus.rsp_zero), 32'h1);
        step();
        check("rx_idle", 32'(bus.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
